// File: rtl/pci_bus_arbiter.sv
// Central PCI arbiter: round-robin grant with turnaround, BUSY tracking and
// a grant timeout for masters that never drive FRAME#.
module pci_bus_arbiter #(
  parameter  int NUM_MASTERS = 3,
  parameter  int GNT_TIMEOUT = 16,
  localparam int OW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clck,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req_n,
  input  logic                   frame_n,
  input  logic                   irdy_n,
  output logic [NUM_MASTERS-1:0] gnt_n,
  output logic [OW-1:0]          owner,
  output logic                   owner_valid,
  output logic                   timeout_pulse
);

  typedef enum logic [1:0] {IDLE, GRANTED, BUSY} state_t;

  state_t                 state, state_d;
  logic [7:0]             timer, timer_d;
  logic [OW-1:0]          last_grant, last_d;
  logic [NUM_MASTERS-1:0] gnt_d;
  logic [OW-1:0]          owner_d;
  logic                   valid_d, pulse_d;
  logic [OW-1:0]          win, cand;
  logic                   any_req;
  logic                   bus_idle;

  assign bus_idle = frame_n & irdy_n;

  // Walk from the farthest candidate to the nearest so the nearest requester
  // after last_grant is the one left standing.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    cand    = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = OW'((int'(last_grant) + i) % NUM_MASTERS);
      if (!req_n[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

  always_comb begin
    state_d = state;
    timer_d = timer;
    last_d  = last_grant;
    gnt_d   = gnt_n;
    owner_d = owner;
    valid_d = owner_valid;
    pulse_d = 1'b0;
    case (state)
      IDLE: begin
        gnt_d   = '1;
        valid_d = 1'b0;
        if (any_req && bus_idle) begin
          gnt_d[win] = 1'b0;
          owner_d    = win;
          valid_d    = 1'b1;
          timer_d    = '0;
          state_d    = GRANTED;
        end
      end
      GRANTED: begin
        if (!frame_n) begin
          last_d  = owner;
          state_d = BUSY;
        end else if (req_n[owner]) begin
          gnt_d   = '1;
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (timer == 8'(GNT_TIMEOUT - 1)) begin
          gnt_d   = '1;
          valid_d = 1'b0;
          pulse_d = 1'b1;
          last_d  = owner;
          state_d = IDLE;
        end else if (timer != '1) begin
          timer_d = timer + 8'd1;
        end
      end
      BUSY: begin
        // Release is sticky: a re-request mid-transaction waits for IDLE.
        if (req_n[owner]) gnt_d[owner] = 1'b1;
        if (bus_idle) begin
          gnt_d   = '1;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '1;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      last_grant    <= OW'(NUM_MASTERS - 1);
      gnt_n         <= '1;
      owner         <= '0;
      owner_valid   <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_d;
      timer         <= timer_d;
      last_grant    <= last_d;
      gnt_n         <= gnt_d;
      owner         <= owner_d;
      owner_valid   <= valid_d;
      timeout_pulse <= pulse_d;
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Bench for pci_bus_arbiter: directed scenarios push expected output events
// (edge index + values) into a queue; a negedge monitor matches them.
module tb_pci_bus_arbiter;

  logic       clck = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req_n = 3'b111;
  logic       frame_n = 1'b1;
  logic       irdy_n = 1'b1;
  logic [2:0] gnt_n;
  logic [1:0] owner;
  logic       owner_valid;
  logic       timeout_pulse;

  pci_bus_arbiter #(.NUM_MASTERS(3), .GNT_TIMEOUT(16)) dut (
    .clck(clck), .rst_n(rst_n), .req_n(req_n), .frame_n(frame_n), .irdy_n(irdy_n),
    .gnt_n(gnt_n), .owner(owner), .owner_valid(owner_valid), .timeout_pulse(timeout_pulse)
  );

  always #5 clck = ~clck;

  typedef struct {
    int         cyc;
    logic [2:0] gnt;
    logic [1:0] own;
    logic       ov;
    logic       tp;
  } ev_t;

  ev_t        sb[$];
  int         edge_cnt = 0;
  int         total = 0;
  int         passes = 0;
  int         viol = 0;
  bit         mon_en = 1'b0;
  logic [2:0] prev_gnt = 3'b111;
  logic       prev_ov = 1'b0;

  task automatic chk(input string name, input bit ok, input int act, input int expv);
    total++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_cnt);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clck);
    #2;
  endtask

  task automatic expect_ev(input int off, input logic [2:0] g, input logic [1:0] o,
                           input logic v, input logic t);
    ev_t e;
    e.cyc = edge_cnt + off; e.gnt = g; e.own = o; e.ov = v; e.tp = t;
    sb.push_back(e);
  endtask

  always @(posedge clck) edge_cnt <= edge_cnt + 1;

  always @(negedge clck) begin
    if ($countones(~gnt_n) > 1) viol <= viol + 1;
  end

  always @(negedge clck) begin
    ev_t e;
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].cyc < edge_cnt) begin
        e = sb.pop_front();
        chk("missed_event", 1'b0, edge_cnt, e.cyc);
      end
      if (gnt_n != prev_gnt || owner_valid != prev_ov || timeout_pulse) begin
        if (sb.size() > 0 && sb[0].cyc == edge_cnt) begin
          e = sb.pop_front();
          chk("gnt_n", gnt_n == e.gnt, gnt_n, e.gnt);
          chk("owner_valid", owner_valid == e.ov, owner_valid, e.ov);
          chk("timeout_pulse", timeout_pulse == e.tp, timeout_pulse, e.tp);
          if (e.ov) chk("owner", owner == e.own, owner, e.own);
        end else begin
          chk("unexpected_event", 1'b0, {gnt_n, owner_valid, timeout_pulse}, 0);
        end
      end
    end
    prev_gnt <= gnt_n;
    prev_ov  <= owner_valid;
  end

  initial begin
    tick(2);
    chk("rst_gnt_n", gnt_n == 3'b111, gnt_n, 3'b111);
    chk("rst_owner", owner == 2'd0, owner, 0);
    chk("rst_owner_valid", owner_valid == 1'b0, owner_valid, 0);
    chk("rst_timeout", timeout_pulse == 1'b0, timeout_pulse, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick(1);

    // A alone: grant, BUSY, release with bus idle
    req_n = 3'b110; expect_ev(1, 3'b110, 2'd0, 1, 0); tick(1);
    frame_n = 1'b0; tick(1);
    req_n = 3'b111; frame_n = 1'b1; expect_ev(1, 3'b111, 2'd0, 0, 0); tick(1);
    tick(1);

    // all requesting: A, B, C, A with an idle gap between grants
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
    req_n = 3'b000;
    foreach (sb[i]) ; // queue is empty here; keeps nothing
    for (int k = 0; k < 4; k++) begin
      logic [1:0] m;
      logic [2:0] g;
      m = 2'(k % 3);
      g = 3'b111; g[m] = 1'b0;
      expect_ev(1, g, m, 1, 0); tick(1);
      frame_n = 1'b0; tick(3);
      frame_n = 1'b1; expect_ev(1, 3'b111, m, 0, 0); tick(1);
    end
    req_n = 3'b111; tick(2);

    // B withdraws before FRAME#: no timeout, B keeps next priority
    req_n = 3'b101; expect_ev(1, 3'b101, 2'd1, 1, 0); tick(1);
    req_n = 3'b111; expect_ev(1, 3'b111, 2'd1, 0, 0); tick(1);
    // B granted again, never starts: timeout after 16 edges, then C
    req_n = 3'b001;
    expect_ev(1, 3'b101, 2'd1, 1, 0);
    expect_ev(17, 3'b111, 2'd1, 0, 1);
    tick(17);
    expect_ev(1, 3'b011, 2'd2, 1, 0); tick(1);
    req_n = 3'b111; expect_ev(1, 3'b111, 2'd2, 0, 0); tick(1);
    tick(1);

    // A in BUSY, async reset mid-cycle, then A first again
    req_n = 3'b110; expect_ev(1, 3'b110, 2'd0, 1, 0); tick(1);
    frame_n = 1'b0; tick(1);
    expect_ev(0, 3'b111, 2'd0, 0, 0);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_gnt_n", gnt_n == 3'b111, gnt_n, 3'b111);
    chk("async_rst_owner_valid", owner_valid == 1'b0, owner_valid, 0);
    req_n = 3'b000; frame_n = 1'b1;
    tick(1);
    rst_n = 1'b1; expect_ev(1, 3'b110, 2'd0, 1, 0); tick(1);
    req_n = 3'b111; expect_ev(1, 3'b111, 2'd0, 0, 0); tick(1);
    tick(1);

    // bus held by a previous owner: no grant until FRAME# and IRDY# both high
    frame_n = 1'b0; irdy_n = 1'b0; req_n = 3'b101; tick(3);
    frame_n = 1'b1; tick(2);
    irdy_n = 1'b1; expect_ev(1, 3'b101, 2'd1, 1, 0); tick(1);
    req_n = 3'b111; expect_ev(1, 3'b111, 2'd1, 0, 0); tick(1);
    tick(2);
    chk("sb_drained", sb.size() == 0, sb.size(), 0);

    // random traffic, invariant only
    mon_en = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      req_n   = 3'($urandom_range(0, 7));
      frame_n = 1'($urandom_range(0, 1));
      irdy_n  = 1'($urandom_range(0, 1));
      tick(1);
    end
    req_n = 3'b111; frame_n = 1'b1; irdy_n = 1'b1; tick(2);
    chk("onehot_violations", viol == 0, viol, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
